fibonacci_checker: RTL and testbench
====================================

FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 SHALL have parameter: WIDTH, 32, width of checked value.
REQ-002 SHALL have parameter: LOCK_TERMS, 4, consecutive matched terms needed to assert locked (range 1..65535).
REQ-003 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  reset, synchronous and active-low (reset==0 resets on the next rising clk edge).
REQ-005 SHALL have port: value_in  input  WIDTH  sequence term under check.
REQ-006 SHALL have port: valid_in  input  1  value_in sampled on an edge only when high.
REQ-007 SHALL have port: locked  output  1  term_count >= LOCK_TERMS while in CHECK.
REQ-008 SHALL have port: error  output  1  sequence violation detected.
REQ-009 SHALL have port: term_count  output  16  terms matched since last sync, saturating at 65535.
REQ-010 SHALL have port: wrap_count  output  8  completed sequence wraps since last sync, saturating at 255.

Function
REQ-011 SHALL keep a reference model: exp_prev, exp_cur (WIDTH bits each); the expected term is always exp_prev.
REQ-012 SHALL advance the model on every accepted match: if exp_cur[WIDTH-1]==1, load exp_cur=1, exp_prev=0 (wrap); else exp_cur=exp_cur+exp_prev (modulo 2^WIDTH), exp_prev=exp_cur.
REQ-013 SHALL implement a three-state machine: HUNT, CHECK and ERROR.
REQ-014 HUNT: a sample with value_in==0 SHALL go to CHECK, load exp_prev=1, exp_cur=1, term_count=1, wrap_count=0; a nonzero sample SHALL stay in HUNT with no error.
REQ-015 CHECK: a sample equal to exp_prev SHALL advance the model and increment term_count; a sample not equal to exp_prev SHALL go to ERROR and leave the counters frozen.
REQ-016 CHECK: a matched sample of 0 that is the expected post-wrap term SHALL increment wrap_count; a 0 at any other point SHALL be a mismatch.
REQ-017 With valid_in low, the block SHALL hold all state, counters and outputs.
REQ-018 All outputs SHALL be registered; each output SHALL reflect a sample on the clk edge that accepts it (latency 1 cycle).
REQ-019 locked SHALL be 1 only in CHECK with term_count >= LOCK_TERMS; it SHALL deassert in the same cycle error asserts.
REQ-020 error SHALL be 1 exactly while in ERROR.
REQ-021 ERROR SHALL keep counters frozen at their last values.

Reset
REQ-022 With reset==0 at a rising edge: state=HUNT, locked=0, error=0, term_count=0, wrap_count=0, exp_prev=0, exp_cur=1.
REQ-023 Reset SHALL take priority over valid_in; samples during reset SHALL be ignored.
REQ-024 Reset asserted mid-sequence SHALL abort the check; the first post-reset sample of 0 SHALL resync per REQ-014.

Configuration
REQ-025 Macro FIB_CHECKER_RESYNC_EN defined: in ERROR, a sample of 0 SHALL act as the HUNT sync of REQ-014 (error clears, CHECK entered); other samples SHALL hold ERROR.
REQ-026 Macro FIB_CHECKER_RESYNC_EN undefined: ERROR SHALL be sticky until reset; all samples SHALL be ignored.

Verification (WIDTH=8, LOCK_TERMS=4)
REQ-027 Reset low 2 cycles, then stream 0,1,1,2,3,5,...,89 at valid_in=1 -> locked rises the edge after the 4th term (2); term_count=12 after 89; error stays 0.
REQ-028 Continue with 0,1,1 after 89 -> wrap_count=1; term_count=15; locked stays 1.
REQ-029 Stream 0,1,1,2,4 -> error=1 and locked=0 the edge after 4; term_count holds 4.
REQ-030 Stream 5,7,0,1 in HUNT -> no error until the 0; CHECK entered; term_count=2 after the 1.
REQ-031 After REQ-029 error, send 0,1: with FIB_CHECKER_RESYNC_EN, error=0 and term_count=2; without it, error stays 1 and term_count stays 4.
REQ-032 Stream 0,1,1 with valid_in low on alternate cycles (garbage on value_in), then reset low mid-stream -> gaps cause no change; reset clears all outputs to 0.

Source files
------------

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: tracks a streamed Fibonacci sequence, syncing on 0 and flagging the first deviation.
// Define FIB_CHECKER_RESYNC_EN to let a 0 sample resynchronise out of ERROR; otherwise ERROR is sticky until reset.
module fibonacci_checker #(
  parameter int WIDTH = 32,
  parameter int LOCK_TERMS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value_in,
  input  logic             valid_in,
  output logic             locked,
  output logic             error,
  output logic [15:0]      term_count,
  output logic [7:0]       wrap_count
);
  typedef enum logic [1:0] {HUNT, CHECK, ERROR} state_t;
  localparam logic [15:0] LOCK = 16'(LOCK_TERMS);
  state_t state, state_n;
  logic [WIDTH-1:0] exp_prev, exp_cur, prev_n, cur_n;
  logic [15:0] term_n;
  logic [7:0] wrap_n;
  logic resync_ok, sync, hit, miss, wrap, zero;
`ifdef FIB_CHECKER_RESYNC_EN
  assign resync_ok = state == ERROR;
`else
  assign resync_ok = 1'b0;
`endif
  assign zero = value_in == '0;
  assign wrap = exp_cur[WIDTH-1];
  assign sync = valid_in && zero && (state == HUNT || resync_ok);
  assign hit  = valid_in && state == CHECK && value_in == exp_prev;
  assign miss = valid_in && state == CHECK && value_in != exp_prev;
  // A matched 0 can only be the post-wrap term: sums never overflow before the top bit triggers a wrap.
  always_comb begin
    state_n = sync ? CHECK : miss ? ERROR : state;
    prev_n  = sync ? WIDTH'(1) : hit ? (wrap ? '0 : exp_cur) : exp_prev;
    cur_n   = sync ? WIDTH'(1) : hit ? (wrap ? WIDTH'(1) : exp_cur + exp_prev) : exp_cur;
    term_n  = sync ? 16'd1 : (hit && term_count != 16'hffff) ? term_count + 16'd1 : term_count;
    wrap_n  = sync ? 8'd0 : (hit && zero && wrap_count != 8'hff) ? wrap_count + 8'd1 : wrap_count;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HUNT;
      exp_prev   <= '0;
      exp_cur    <= WIDTH'(1);
      term_count <= '0;
      wrap_count <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      exp_prev   <= prev_n;
      exp_cur    <= cur_n;
      term_count <= term_n;
      wrap_count <= wrap_n;
      locked     <= state_n == CHECK && term_n >= LOCK;
      error      <= state_n == ERROR;
    end
  end
endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_fibonacci_checker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] value_in = '0;
  logic valid_in = 1'b0;
  logic locked, error;
  logic [15:0] term_count;
  logic [7:0] wrap_count;
  typedef struct {
    string name;
    logic lk, er;
    logic [15:0] tc;
    logic [7:0] wc;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  fibonacci_checker #(.WIDTH(8), .LOCK_TERMS(4)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .valid_in(valid_in),
    .locked(locked), .error(error), .term_count(term_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic r, input logic v, input logic [7:0] val,
                      input logic lk, input logic er, input logic [15:0] tc, input logic [7:0] wc);
    exp_t e;
    @(negedge clk);
    reset = r;
    valid_in = v;
    value_in = val;
    e.name = name; e.lk = lk; e.er = er; e.tc = tc; e.wc = wc;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || error !== e.er || term_count !== e.tc || wrap_count !== e.wc) begin
        errors++;
        $display("FAIL %s: got locked=%b error=%b term=%0d wrap=%0d, want locked=%b error=%b term=%0d wrap=%0d",
                 e.name, locked, error, term_count, wrap_count, e.lk, e.er, e.tc, e.wc);
      end
    end
  end

  initial begin
    logic [7:0] fib [12] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89};
    step("reset0", 0, 1, 8'd0, 0, 0, 0, 0);
    step("reset1", 0, 1, 8'd0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      step($sformatf("fib%0d", i), 1, 1, fib[i], i >= 3, 0, 16'(i + 1), 0);
    step("wrap0", 1, 1, 8'd0, 1, 0, 13, 1);
    step("wrap1", 1, 1, 8'd1, 1, 0, 14, 1);
    step("wrap2", 1, 1, 8'd1, 1, 0, 15, 1);
    step("rst_a", 0, 1, 8'd1, 0, 0, 0, 0);
    step("bad0", 1, 1, 8'd0, 0, 0, 1, 0);
    step("bad1", 1, 1, 8'd1, 0, 0, 2, 0);
    step("bad2", 1, 1, 8'd1, 0, 0, 3, 0);
    step("bad3", 1, 1, 8'd2, 1, 0, 4, 0);
    step("bad4", 1, 1, 8'd4, 0, 1, 4, 0);
    step("err_hold", 1, 1, 8'd3, 0, 1, 4, 0);
`ifdef FIB_CHECKER_RESYNC_EN
    step("resync0", 1, 1, 8'd0, 0, 0, 1, 0);
    step("resync1", 1, 1, 8'd1, 0, 0, 2, 0);
`else
    step("sticky0", 1, 1, 8'd0, 0, 1, 4, 0);
    step("sticky1", 1, 1, 8'd1, 0, 1, 4, 0);
`endif
    step("rst_b", 0, 1, 8'd0, 0, 0, 0, 0);
    step("hunt5", 1, 1, 8'd5, 0, 0, 0, 0);
    step("hunt7", 1, 1, 8'd7, 0, 0, 0, 0);
    step("hunt0", 1, 1, 8'd0, 0, 0, 1, 0);
    step("hunt1", 1, 1, 8'd1, 0, 0, 2, 0);
    step("rst_c", 0, 0, 8'd0, 0, 0, 0, 0);
    step("gap_s0", 1, 1, 8'd0, 0, 0, 1, 0);
    step("gap_g0", 1, 0, 8'd77, 0, 0, 1, 0);
    step("gap_s1", 1, 1, 8'd1, 0, 0, 2, 0);
    step("gap_g1", 1, 0, 8'd0, 0, 0, 2, 0);
    step("gap_s2", 1, 1, 8'd1, 0, 0, 3, 0);
    step("gap_g2", 1, 0, 8'd200, 0, 0, 3, 0);
    step("gap_rst", 0, 1, 8'd2, 0, 0, 0, 0);
    step("post_rst", 1, 1, 8'd1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
